// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = in1 - in2 - bin, one 4-bit lookahead
// nibble per clock with the borrow carried in a register between nibbles.
// Subtraction is done as in1 + ~in2 + ~bin, so the internal carry is the
// inverted borrow throughout.

// 4-bit generate/propagate lookahead adder used for each nibble step.
module nibble_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead: every carry is a two-level function of g/p/ci.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];
endmodule

module nibble_serial_subtractor #(
  parameter int N = 32  // multiple of 4, >= 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);
  localparam int M  = N / 4;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q;      // minuend, shifted down one nibble per step
  logic [N-1:0]  b_q;      // inverted subtrahend, shifted the same way
  logic          carry_q;  // inverted borrow between nibbles
  logic [CW-1:0] cnt_q;
  logic          a_msb_q;
  logic          b_msb_q;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, ovf_q, zero_q;

  logic [3:0]    nib_s;
  logic          nib_co;
  logic          last;
  logic          accept;
  logic          release_res;

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign last        = (cnt_q == CW'(M - 1));

  // Only the low nibble of the shifted operands feeds the adder, so the
  // nibble select costs no wide mux.
  nibble_cla u_cla (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  // Result nibble k lands in place; other nibbles keep their value so the
  // partial difference is readable while running.
  for (genvar k = 0; k < M; k++) begin : g_nib
    assign diff_d[4*k +: 4] = (cnt_q == CW'(k)) ? nib_s : diff_q[4*k +: 4];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; no accept bypass out of DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (release_res) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is held low during reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = !rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture at accept, one nibble step per RUN cycle, flags with the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= in1;
            b_q     <= ~in2;
            carry_q <= ~bin;
            cnt_q   <= '0;
            a_msb_q <= in1[N-1];
            b_msb_q <= in2[N-1];
          end
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= nib_co;
          diff_q  <= diff_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            bout_q <= ~nib_co;
            // Operand signs differ and result sign departs from the minuend.
            ovf_q  <= (a_msb_q != b_msb_q) && (nib_s[3] != a_msb_q);
            zero_q <= (diff_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed and throttled-random checks of nibble_serial_subtractor at N=32
// and N=8 against a plain arithmetic model.
module tb_nibble_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in1, in2, diff;
  logic        bin, bout, ovf, zero;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in1_8, in2_8, diff8;
  logic        bin8, bout8, ovf8, zero8;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .bin(bin), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  nibble_serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in1(in1_8), .in2(in2_8), .bin(bin8), .out_valid(out_valid8),
    .out_ready(out_ready8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {bout, ovf, zero, diff}
  function automatic logic [34:0] ref32(input logic [31:0] a, b, input logic bi);
    logic [32:0] t;
    logic [31:0] d;
    t = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    d = t[31:0];
    return {t[32], (a[31] != b[31]) && (d[31] != a[31]), d == 32'd0, d};
  endfunction

  function automatic logic [10:0] ref8(input logic [7:0] a, b, input logic bi);
    logic [8:0] t;
    logic [7:0] d;
    t = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    d = t[7:0];
    return {t[8], (a[7] != b[7]) && (d[7] != a[7]), d == 8'd0, d};
  endfunction

  // Present operands, wait for accept, scramble inputs, wait for out_valid.
  task automatic send32(input logic [31:0] a, b, input logic bi, input int gap, output int lat);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in1 = a; in2 = b; bin = bi; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("accept32 timeout", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = ~a; in2 = ~b; bin = ~bi;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop32();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, b, input logic bi, input int gap, output int lat);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in1_8 = a; in2_8 = b; bin8 = bi; in_valid8 = 1'b1;
    t = 0;
    while (!in_ready8 && t < 50) begin @(posedge clk); #1; t++; end
    chk("accept8 timeout", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; in1_8 = ~a; in2_8 = ~b; bin8 = ~bi;
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  // Directed vector: send, check latency/diff/flags, release.
  task automatic vec32(input string tag, input logic [31:0] a, b, input logic bi,
                       input logic [31:0] ed, input logic eb, eo, ez);
    int lat;
    send32(a, b, bi, 0, lat);
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " bout"}, 32'(bout), 32'(eb));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    chk({tag, " zero"}, 32'(zero), 32'(ez));
    pop32();
    chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat, pulses, gap_o;
    logic [31:0] ra, rb;
    logic [7:0]  sa, sb;
    logic        rbi;
    logic [34:0] e32;
    logic [10:0] e8;

    rst = 1'b1;
    in_valid = 0; out_ready = 0; in1 = 0; in2 = 0; bin = 0;
    in_valid8 = 0; out_ready8 = 0; in1_8 = 0; in2_8 = 0; bin8 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst diff", diff, 32'd0);
    chk("rst flags", {29'd0, bout, ovf, zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    chk("post-rst in_ready8", 32'(in_ready8), 32'd1);

    vec32("5-3",      32'h5,        32'h3,        1'b0, 32'h2,        1'b0, 1'b0, 1'b0);
    vec32("3-5",      32'h3,        32'h5,        1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    vec32("5-5-1",    32'h5,        32'h5,        1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    vec32("min-1",    32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    vec32("ripple",   32'h00010000, 32'h1,        1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);

    // Equal operands, then hold the result with out_ready low and a new op pending.
    send32(32'h12345678, 32'h12345678, 1'b0, 0, lat);
    chk("eq latency", 32'(lat), 32'd8);
    chk("eq diff", diff, 32'd0);
    chk("eq zero", 32'(zero), 32'd1);
    chk("eq bout", 32'(bout), 32'd0);
    in1 = 32'h0000AAAA; in2 = 32'h1; bin = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      chk("hold diff", diff, 32'd0);
      chk("hold zero", 32'(zero), 32'd1);
    end
    pop32();
    chk("release out_valid", 32'(out_valid), 32'd0);
    chk("release in_ready", 32'(in_ready), 32'd1);
    send32(32'h0000AAAA, 32'h1, 1'b0, 0, lat);
    chk("after-hold latency", 32'(lat), 32'd8);
    chk("after-hold diff", diff, 32'h0000AAA9);
    pop32();

    // Abort mid-RUN with reset.
    in1 = 32'h0000FFFF; in2 = 32'h1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("run in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst-high in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("abort no result", 32'(pulses), 32'd0);
    vec32("0x10-1", 32'h10, 32'h1, 1'b0, 32'h0000000F, 1'b0, 1'b0, 1'b0);

    // Throttled random traffic, N=32.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
      if (i % 10 == 0) rb = ra;
      if (i % 10 == 1) rb = ra ^ 32'h80000000;
      e32 = ref32(ra, rb, rbi);
      send32(ra, rb, rbi, $urandom_range(0, 2), lat);
      gap_o = $urandom_range(0, 2);
      repeat (gap_o) begin @(posedge clk); #1; end
      chk("r32 latency", 32'(lat), 32'd8);
      chk("r32 diff", diff, e32[31:0]);
      chk("r32 flags", {29'd0, bout, ovf, zero}, {29'd0, e32[34:32]});
      pop32();
    end

    // Throttled random traffic, N=8.
    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom); sb = 8'($urandom); rbi = 1'($urandom_range(0, 1));
      if (i % 10 == 0) sb = sa;
      e8 = ref8(sa, sb, rbi);
      send8(sa, sb, rbi, $urandom_range(0, 2), lat);
      gap_o = $urandom_range(0, 2);
      repeat (gap_o) begin @(posedge clk); #1; end
      chk("r8 latency", 32'(lat), 32'd2);
      chk("r8 diff", {24'd0, diff8}, {24'd0, e8[7:0]});
      chk("r8 flags", {29'd0, bout8, ovf8, zero8}, {29'd0, e8[10:8]});
      pop8();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
